// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [PC_W-1:0] PC_STEP      = 32'd4;
    localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ROM bus, redirect/halt controls and decode handshake of the fetch sequencer.
interface inst_fetch_ctrl_if;
    import fetch_pkg::*;

    logic [PC_W-1:0]   rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output rom_addr, out_valid, out_inst, out_pc,
        input  rom_inst, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_inst, out_pc,
        output rom_inst, redirect_valid, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, inst} with synchronous flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] occ
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wp, rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign valid = (occ != '0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: PC, ROM issue with credit check, optional in-flight tracker.
// Build option: FETCH_ROM_SYNC_EN selects a one-cycle-latency ROM.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] PC_INIT = {RESET_PC[PC_W-1:2], 2'b00};

    logic [PC_W-1:0] pc;
    logic [CW-1:0]   occ;
    logic            inflight, issue, push, pop, head_vld;
    fetch_entry_t    push_entry, head;

    // Credits use the registered occupancy, so a pop never frees a slot for the same cycle.
    assign pop   = head_vld && bus.out_ready;
    assign issue = !bus.halt && !bus.redirect_valid && ((occ + CW'(inflight)) < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pc <= PC_INIT;
        else if (bus.redirect_valid) pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        else if (issue)              pc <= pc + PC_STEP;
    end

`ifdef FETCH_ROM_SYNC_EN
    logic            trk_vld, trk_killed;
    logic [PC_W-1:0] trk_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld    <= 1'b0;
            trk_killed <= 1'b0;
            trk_pc     <= '0;
        end else begin
            trk_vld    <= issue;
            trk_pc     <= pc;
            trk_killed <= bus.redirect_valid;
        end
    end

    assign inflight   = trk_vld;
    assign push       = trk_vld && !trk_killed && !bus.redirect_valid;
    assign push_entry = '{pc: trk_pc, inst: bus.rom_inst};
`else
    assign inflight   = 1'b0;
    assign push       = issue;
    assign push_entry = '{pc: pc, inst: bus.rom_inst};
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .valid (head_vld),
        .occ   (occ)
    );

    // Outputs read as zero while empty so stale storage never shows through.
    assign bus.rom_addr  = pc;
    assign bus.out_valid = head_vld;
    assign bus.out_inst  = head_vld ? head.inst : '0;
    assign bus.out_pc    = head_vld ? head.pc : '0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; ROM word = addr ^ 32'hA5A5_0000.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_ROM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_ctrl_if bus();

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

`ifdef FETCH_ROM_SYNC_EN
    always @(posedge clk) bus.rom_inst <= romf(bus.rom_addr);
`else
    assign bus.rom_inst = romf(bus.rom_addr);
`endif

    int checks = 0;
    int fails  = 0;
    int ndeliv = 0;
    int d0;
    logic [31:0] exp_next = 32'd0;

    typedef struct {
        logic        rdy;
        logic        hlt;
        logic        rdr;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({nm, " out_pc"},    bus.out_pc,   32'd0);
        chk({nm, " out_inst"},  bus.out_inst, 32'd0);
        chk({nm, " rom_addr"},  bus.rom_addr, 32'd0);
    endtask

    // Evaluate the current cycle (inputs already set), then advance to the next.
    task automatic step();
        if (bus.out_valid && bus.out_ready) begin
            chk("stream pc",   bus.out_pc,   exp_next);
            chk("stream inst", bus.out_inst, romf(exp_next));
            exp_next += 32'd4;
            ndeliv++;
        end
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with rst_n just released: cycle 1 follows.
    task automatic do_reset();
        bus.out_ready      = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rdy hlt rdr rpc | ev epc eaddr; one row per cycle from reset release
`ifdef FETCH_ROM_SYNC_EN
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'hC};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h10};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h10};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h10};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h10};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h14};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'hC,   32'h18};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h108};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h10C};
`else
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h8};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'hC};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h10};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h14};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h14};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h14};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   32'h18};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h10,  32'h1C};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 32'h108};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 32'h10C};
`endif

        // Table: backpressure, conservative credit, redirect, halt
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            bus.out_ready      = tbl[i].rdy;
            bus.halt           = tbl[i].hlt;
            bus.redirect_valid = tbl[i].rdr;
            bus.redirect_pc    = tbl[i].rpc;
            chk($sformatf("row%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d out_pc", i), bus.out_pc, tbl[i].ev ? tbl[i].epc : 32'd0);
            chk($sformatf("row%0d out_inst", i), bus.out_inst, tbl[i].ev ? romf(tbl[i].epc) : 32'd0);
            chk($sformatf("row%0d rom_addr", i), bus.rom_addr, tbl[i].eaddr);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;

        // Streaming from reset: first valid after LAT cycles, then one per cycle
        do_reset();
        bus.out_ready = 1'b1;
        exp_next = 32'd0;
        d0 = ndeliv;
        begin
            int first = 0;
            for (int c = 1; c <= 20; c++) begin
                if (bus.out_valid && first == 0) first = c;
                step();
            end
            chk("first valid cycle", first, LAT);
        end
        chk("stream count", ndeliv - d0, 20 - LAT + 1);

        // Ten cycles of backpressure fill exactly DEPTH entries
        do_reset();
        repeat (10) step();
        chk("bp rom_addr", bus.rom_addr, 32'(4 * DEPTH));
        chk("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp head pc", bus.out_pc, 32'd0);
        exp_next = 32'd0;
        bus.out_ready = 1'b1;
        d0 = ndeliv;
        repeat (8) step();
        chk("bp drain count", ndeliv - d0, 8);

        // Redirect with the buffer loaded and a read outstanding
        do_reset();
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            chk("redir gap valid", {31'b0, bus.out_valid}, 32'd0);
            step();
        end
        chk("redir valid", {31'b0, bus.out_valid}, 32'd1);
        chk("redir pc", bus.out_pc, 32'h0000_0100);
        exp_next = 32'h0000_0100;
        repeat (4) step();

        // Halt drains the pipe, then fetch resumes sequentially
        bus.halt = 1'b1;
        repeat (4) step();
        chk("halt drained", {31'b0, bus.out_valid}, 32'd0);
        step();
        bus.halt = 1'b0;
        d0 = ndeliv;
        repeat (6) step();
        chk("halt resume count", ndeliv - d0, 6 - LAT + 1);

        // PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        exp_next = 32'hFFFF_FFF8;
        d0 = ndeliv;
        repeat (LAT + 3) step();
        chk("wrap count", ndeliv - d0, 4);

        // Asynchronous reset mid-stream with a redirect pending
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("async reset");
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_next = 32'd0;
        d0 = ndeliv;
        repeat (LAT + 3) step();
        chk("restart count", ndeliv - d0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
